// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int MAX_NSTAGE = 32;
  localparam int IDX_W      = 5;

  typedef logic [IDX_W-1:0]      stage_idx_t;
  typedef logic [IDX_W-1:0]      redir_idx_t;
  typedef logic [MAX_NSTAGE-1:0] stage_mask_t;

  // Default stage of each redirect source: exception at writeback, branch and
  // jr at execute, early decode redirect at stage 2.
  localparam stage_idx_t [0:3] REDIR_STAGE_DEF = {5'd7, 5'd5, 5'd5, 5'd2};

  // Stages younger than s are bubbled; s itself only when the source kills itself.
  function automatic stage_mask_t flushMask(input stage_idx_t s, input logic killSelf);
    stage_mask_t m;
    m = '0;
    for (int k = 0; k < MAX_NSTAGE; k++) begin
      if ((k < int'(s)) || (killSelf && (k == int'(s)))) m[k] = 1'b1;
    end
    return m;
  endfunction

  // A stall at s holds s and every younger stage.
  function automatic stage_mask_t stallMask(input stage_idx_t s);
    stage_mask_t m;
    m = '0;
    for (int k = 0; k < MAX_NSTAGE; k++) begin
      if (k <= int'(s)) m[k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fetch_squash_tracker.sv
// Tracks outstanding I-fetch requests and how many in-flight responses belong
// to a redirected (dead) fetch stream, so they are dropped rather than stalling fetch.
module fetch_squash_tracker #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic if_req_fire,
  input  logic if_resp_valid,
  input  logic redirGrant,
  output logic resp_drop,
  output logic squash_busy,
  output logic cnt_err
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  logic [CW-1:0] inflight;
  logic [CW-1:0] squash;

  // In-flight counter with sticky overflow/underflow detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inflight <= '0;
      cnt_err  <= 1'b0;
    end else begin
      case ({if_req_fire, if_resp_valid})
        2'b10: begin
          if (inflight == CW'(MAX_INFLIGHT)) cnt_err <= 1'b1;
          else inflight <= inflight + CW'(1);
        end
        2'b01: begin
          if (inflight == '0) cnt_err <= 1'b1;
          else inflight <= inflight - CW'(1);
        end
        default: inflight <= inflight;
      endcase
    end
  end

  // Squash counter: reloaded (never accumulated) on a redirect; a response in
  // the redirect cycle is already dropped, and a request fired in that cycle is
  // on the new path, so neither is counted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      squash <= '0;
    end else if (redirGrant) begin
      if (if_resp_valid) squash <= (inflight != '0) ? inflight - CW'(1) : '0;
      else squash <= inflight;
    end else if (if_resp_valid && (squash != '0)) begin
      squash <= squash - CW'(1);
    end
  end

  // Drop any response arriving while the old stream is being drained.
  always_comb begin
    squash_busy = (squash != '0);
    resp_drop   = resetn & if_resp_valid & (redirGrant | (squash != '0));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: age-ordered arbitration of stall and redirect
// requests, per-stage stall/flush generation and fetch-queue flush.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int                        NSTAGE          = 8,
  parameter int                        NREDIR          = 4,
  parameter int                        MAX_INFLIGHT    = 4,
  parameter stage_idx_t [0:NREDIR-1]   REDIR_STAGE     = REDIR_STAGE_DEF,
  parameter logic [NREDIR-1:0]         REDIR_KILL_SELF = 4'b0001,
  parameter logic [NREDIR-1:0]         REDIR_PREEMPT   = 4'b0001,
  parameter int                        QUE_STAGE       = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NSTAGE-1:0] stall_req,
  input  logic [NREDIR-1:0] redir_req,
  input  logic              if_req_fire,
  input  logic              if_resp_valid,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic              que_flush,
  output logic [NREDIR-1:0] redir_grant,
  output logic              resp_drop,
  output logic              squash_busy,
  output logic              cnt_err
);

  logic found;
  logic winIsRedir;
  logic winKill;
  int   winStage;
  int   winSrc;

  // Oldest stage first; within a stage: preempting redirect, stall, other redirect.
  always_comb begin
    found      = 1'b0;
    winIsRedir = 1'b0;
    winKill    = 1'b0;
    winStage   = 0;
    winSrc     = 0;
    for (int s = NSTAGE - 1; s >= 0; s--) begin
      for (int r = 0; r < NREDIR; r++) begin
        if (!found && redir_req[r] && REDIR_PREEMPT[r] && (int'(REDIR_STAGE[r]) == s)) begin
          found      = 1'b1;
          winIsRedir = 1'b1;
          winKill    = REDIR_KILL_SELF[r];
          winStage   = s;
          winSrc     = r;
        end
      end
      if (!found && stall_req[s]) begin
        found    = 1'b1;
        winStage = s;
      end
      for (int r = 0; r < NREDIR; r++) begin
        if (!found && redir_req[r] && !REDIR_PREEMPT[r] && (int'(REDIR_STAGE[r]) == s)) begin
          found      = 1'b1;
          winIsRedir = 1'b1;
          winKill    = REDIR_KILL_SELF[r];
          winStage   = s;
          winSrc     = r;
        end
      end
    end
  end

  // Turn the winner into stall/flush/grant masks; reset forces a full flush.
  always_comb begin
    stall       = '0;
    flush       = '0;
    que_flush   = 1'b0;
    redir_grant = '0;
    if (!resetn) begin
      flush     = '1;
      que_flush = 1'b1;
    end else if (found && winIsRedir) begin
      flush     = NSTAGE'(flushMask(stage_idx_t'(winStage), winKill));
      que_flush = (winStage > QUE_STAGE) || ((winStage == QUE_STAGE) && winKill);
      for (int r = 0; r < NREDIR; r++) redir_grant[r] = (r == winSrc);
    end else if (found) begin
      stall = NSTAGE'(stallMask(stage_idx_t'(winStage)));
      for (int k = 0; k < NSTAGE; k++) flush[k] = (k == winStage + 1);
    end
  end

  fetch_squash_tracker #(
    .MAX_INFLIGHT(MAX_INFLIGHT)
  ) u_tracker (
    .clk          (clk),
    .resetn       (resetn),
    .if_req_fire  (if_req_fire),
    .if_resp_valid(if_resp_valid),
    .redirGrant   (|redir_grant),
    .resp_drop    (resp_drop),
    .squash_busy  (squash_busy),
    .cnt_err      (cnt_err)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: arbitration vector table plus
// hand-written squash/counter/reset sequences.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] stall_req;
  logic [3:0] redir_req;
  logic       if_req_fire;
  logic       if_resp_valid;
  logic [7:0] stall;
  logic [7:0] flush;
  logic       que_flush;
  logic [3:0] redir_grant;
  logic       resp_drop;
  logic       squash_busy;
  logic       cnt_err;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .stall_req    (stall_req),
    .redir_req    (redir_req),
    .if_req_fire  (if_req_fire),
    .if_resp_valid(if_resp_valid),
    .stall        (stall),
    .flush        (flush),
    .que_flush    (que_flush),
    .redir_grant  (redir_grant),
    .resp_drop    (resp_drop),
    .squash_busy  (squash_busy),
    .cnt_err      (cnt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] stallReq;
    logic [3:0] redirReq;
    logic [7:0] expStall;
    logic [7:0] expFlush;
    logic       expQue;
    logic [3:0] expGrant;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs half a cycle before the next rising edge, settle 1 time unit.
  task automatic drive(input logic f, input logic r, input logic [3:0] rd);
    @(negedge clk);
    stall_req     = 8'h00;
    redir_req     = rd;
    if_req_fire   = f;
    if_resp_valid = r;
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    resetn        = 1'b0;
    stall_req     = 8'h00;
    redir_req     = 4'h0;
    if_req_fire   = 1'b0;
    if_resp_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{8'h01, 4'b0000, 8'h01, 8'h02, 1'b0, 4'b0000};
    vecs[1]  = '{8'h20, 4'b0010, 8'h3F, 8'h40, 1'b0, 4'b0000};
    vecs[2]  = '{8'h20, 4'b0001, 8'h00, 8'hFF, 1'b1, 4'b0001};
    vecs[3]  = '{8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 4'b0000};
    vecs[4]  = '{8'h00, 4'b0100, 8'h00, 8'h1F, 1'b1, 4'b0100};
    vecs[5]  = '{8'h00, 4'b1000, 8'h00, 8'h03, 1'b0, 4'b1000};
    vecs[6]  = '{8'h00, 4'b0110, 8'h00, 8'h1F, 1'b1, 4'b0010};
    vecs[7]  = '{8'h80, 4'b0001, 8'h00, 8'hFF, 1'b1, 4'b0001};
    vecs[8]  = '{8'h80, 4'b0000, 8'hFF, 8'h00, 1'b0, 4'b0000};
    vecs[9]  = '{8'h08, 4'b0100, 8'h00, 8'h1F, 1'b1, 4'b0100};
    vecs[10] = '{8'h40, 4'b1010, 8'h7F, 8'h80, 1'b0, 4'b0000};
    vecs[11] = '{8'h04, 4'b1000, 8'h07, 8'h08, 1'b0, 4'b0000};
    vecs[12] = '{8'h02, 4'b1000, 8'h00, 8'h03, 1'b0, 4'b1000};

    // Reset state, with every request asserted to prove it is masked.
    resetn        = 1'b0;
    stall_req     = 8'hFF;
    redir_req     = 4'hF;
    if_req_fire   = 1'b0;
    if_resp_valid = 1'b1;
    #1;
    check("rst_flush", flush, 8'hFF);
    check("rst_stall", stall, 8'h00);
    check("rst_que", que_flush, 1'b1);
    check("rst_grant", redir_grant, 4'h0);
    check("rst_drop", resp_drop, 1'b0);
    check("rst_busy", squash_busy, 1'b0);
    check("rst_err", cnt_err, 1'b0);
    @(negedge clk);
    if_resp_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    // Arbitration table.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      stall_req     = vecs[i].stallReq;
      redir_req     = vecs[i].redirReq;
      if_req_fire   = 1'b0;
      if_resp_valid = 1'b0;
      #1;
      check($sformatf("vec%0d_stall", i), stall, vecs[i].expStall);
      check($sformatf("vec%0d_flush", i), flush, vecs[i].expFlush);
      check($sformatf("vec%0d_que", i), que_flush, vecs[i].expQue);
      check($sformatf("vec%0d_grant", i), redir_grant, vecs[i].expGrant);
    end

    // Squash drain: 3 in flight, redirect with fire+response in same cycle.
    doReset();
    repeat (3) drive(1'b1, 1'b0, 4'b0000);
    drive(1'b1, 1'b1, 4'b0001);
    check("sqA_redir_drop", resp_drop, 1'b1);
    check("sqA_redir_grant", redir_grant, 4'b0001);
    drive(1'b0, 1'b0, 4'b0000);
    check("sqA_busy_after_redir", squash_busy, 1'b1);
    drive(1'b0, 1'b1, 4'b0000);
    check("sqA_drop1", resp_drop, 1'b1);
    drive(1'b0, 1'b1, 4'b0000);
    check("sqA_drop2", resp_drop, 1'b1);
    check("sqA_busy_during_drop2", squash_busy, 1'b1);
    drive(1'b0, 1'b0, 4'b0000);
    check("sqA_busy_fell", squash_busy, 1'b0);
    drive(1'b0, 1'b1, 4'b0000);
    check("sqA_pass3", resp_drop, 1'b0);
    drive(1'b0, 1'b0, 4'b0000);
    check("sqA_no_err", cnt_err, 1'b0);

    // Repeat redirect while squashing reloads instead of accumulating.
    doReset();
    repeat (3) drive(1'b1, 1'b0, 4'b0000);
    drive(1'b0, 1'b1, 4'b0001);
    check("sqB_redir1_drop", resp_drop, 1'b1);
    drive(1'b1, 1'b0, 4'b0001);
    check("sqB_redir2_nodrop", resp_drop, 1'b0);
    drive(1'b0, 1'b1, 4'b0000);
    check("sqB_drop1", resp_drop, 1'b1);
    drive(1'b0, 1'b1, 4'b0000);
    check("sqB_drop2", resp_drop, 1'b1);
    drive(1'b0, 1'b1, 4'b0000);
    check("sqB_pass3", resp_drop, 1'b0);
    drive(1'b0, 1'b0, 4'b0000);
    check("sqB_no_err", cnt_err, 1'b0);
    check("sqB_idle", squash_busy, 1'b0);

    // Reset asserted mid-squash clears everything immediately.
    repeat (2) drive(1'b1, 1'b0, 4'b0000);
    drive(1'b0, 1'b0, 4'b0001);
    drive(1'b0, 1'b0, 4'b0000);
    check("sqR_busy_before", squash_busy, 1'b1);
    @(negedge clk);
    redir_req     = 4'b0001;
    if_resp_valid = 1'b1;
    resetn        = 1'b0;
    #1;
    check("sqR_busy", squash_busy, 1'b0);
    check("sqR_flush", flush, 8'hFF);
    check("sqR_stall", stall, 8'h00);
    check("sqR_que", que_flush, 1'b1);
    check("sqR_grant", redir_grant, 4'h0);
    check("sqR_drop", resp_drop, 1'b0);
    @(negedge clk);
    redir_req     = 4'b0000;
    if_resp_valid = 1'b0;
    resetn        = 1'b1;

    // Underflow after reset (counter must be back at 0): sticky cnt_err.
    drive(1'b0, 1'b1, 4'b0000);
    check("uf_drop", resp_drop, 1'b0);
    drive(1'b0, 1'b0, 4'b0000);
    check("uf_err", cnt_err, 1'b1);
    drive(1'b1, 1'b0, 4'b0000);
    drive(1'b0, 1'b0, 4'b0000);
    check("uf_err_sticky", cnt_err, 1'b1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("uf_err_cleared", cnt_err, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    // Full counter: fire+response is legal, a further lone fire overflows.
    repeat (4) drive(1'b1, 1'b0, 4'b0000);
    drive(1'b1, 1'b1, 4'b0000);
    drive(1'b0, 1'b0, 4'b0000);
    check("ov_simul_ok", cnt_err, 1'b0);
    repeat (4) drive(1'b0, 1'b1, 4'b0000);
    drive(1'b0, 1'b0, 4'b0000);
    check("ov_drain_ok", cnt_err, 1'b0);
    repeat (4) drive(1'b1, 1'b0, 4'b0000);
    drive(1'b0, 1'b0, 4'b0000);
    check("ov_full_ok", cnt_err, 1'b0);
    drive(1'b1, 1'b0, 4'b0000);
    drive(1'b0, 1'b0, 4'b0000);
    check("ov_err", cnt_err, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard controller for the NSTAGE in-order core; the successor to the fixed-stage hazard unit. It arbitrates per-stage stall requests and per-source redirect requests (exception, branch, jr, …) by stage age, and drives per-stage stall/flush and a fetch-queue flush. It also tracks outstanding I-fetch requests, so that responses in flight at a redirect are dropped instead of stalling fetch. It sits beside the pipeline registers, fed by caches, execute, branch resolution and commit.

## Interface
- NSTAGE, 8, pipeline stages; index 0 = fetch (youngest), NSTAGE-1 = writeback (oldest)
- NREDIR, 4, redirect sources
- MAX_INFLIGHT, 4, max outstanding I-fetch requests
- REDIR_STAGE, {7,5,5,2}, packed array of NREDIR stage indices, one per source
- REDIR_KILL_SELF, 4'b0001, bit r: source r also flushes its own stage
- REDIR_PREEMPT, 4'b0001, bit r: source r beats a stall request at its own stage
- QUE_STAGE, 2, first stage behind the fetch queue

Ports:
- clk  in  1  clock
- resetn  in  1  reset; one clock, reset asynchronous and active-low
- stall_req  in  NSTAGE  bit s: stage s cannot advance (i_wait = bit 0, d_wait, e_wait, …)
- redir_req  in  NREDIR  bit r: source r requests redirect this cycle
- if_req_fire  in  1  I-fetch request accepted this cycle
- if_resp_valid  in  1  I-fetch response returned this cycle
- stall  out  NSTAGE  hold stage s register
- flush  out  NSTAGE  clear stage s register (bubble)
- que_flush  out  1  flush fetch queue
- redir_grant  out  NREDIR  one-hot winning redirect, 0 if none
- resp_drop  out  1  discard this cycle's I-fetch response
- squash_busy  out  1  squash counter non-zero
- cnt_err  out  1  sticky: in-flight counter overflow/underflow

## Operation
- Arbitration (combinational): scan stages from NSTAGE-1 down to 0; first non-empty class wins:
  - preempting redirects at s
  - then stall_req[s]
  - then non-preempting redirects at s
- Same-stage redirect tie: lowest r wins. All losing events are ignored this cycle; requesters hold their request.
- Redirect winner r at stage s:
  - flush[k]=1 for k<s; flush[s]=1 if REDIR_KILL_SELF[r]
  - stall=0, redir_grant[r]=1
  - que_flush=1 if s>QUE_STAGE, or s==QUE_STAGE with KILL_SELF
- Stall winner at s: stall[k]=1 for k≤s; flush[s+1]=1 if s<NSTAGE-1; no redirect granted.
- No event: all zero.
- In-flight counter `inflight` (width $clog2(MAX_INFLIGHT+1)):
  - next = inflight + if_req_fire − if_resp_valid
  - fire at MAX_INFLIGHT without a response: ignored, cnt_err set
  - response at 0 without a fire: ignored, cnt_err set
- Squash counter `squash`:
  - on a granted redirect: squash ← inflight − if_resp_valid. The request fired in the redirect cycle carries the new PC and is not squashed.
  - otherwise, if if_resp_valid and squash>0: squash ← squash−1
  - repeat redirect while squash>0: reloads with the same formula; no accumulation
- resp_drop = if_resp_valid & (redirect granted | squash>0).
- Fetch never stalls because of a redirect. Squashed responses are dropped by resp_drop, replacing the old iwait-flag scheme.

## Timing
- All stall/flush/grant/que_flush/resp_drop are combinational from same-cycle inputs plus registered counters; zero latency.
- Counters and cnt_err update on posedge clk.
- While resetn=0 (asynchronous):
  - inflight=0, squash=0, cnt_err=0
  - flush='1, stall='0, que_flush=1, redir_grant=0, resp_drop=0, squash_busy=0
- Reset mid-squash discards all tracking; the fetch unit is reset in the same cycle.
- First cycle after deassertion: normal arbitration.
- Simultaneous fire + response at inflight==MAX_INFLIGHT: legal; count unchanged.

## Structure
- pipe_ctrl_pkg: stage_idx_t, redir_idx_t, a localparam-function computing the flush mask from a stage index and kill_self, and the default REDIR_STAGE vector.
- Sub-module fetch_squash_tracker holds the inflight/squash counters, resp_drop and cnt_err. The top level holds arbitration and mask generation.

## Test plan
- stall_req=8'b0000_0001 only -> stall=0x01, flush=0x02, no grant.
- stall_req[5]=1 with redir_req[1] (stage 5, non-preempt) -> stall=0x3F, flush=0x40, redir_grant=0.
- redir_req[0] (stage 7, kill_self) with stall_req[5]=1 -> flush=0xFF, stall=0, grant=4'b0001, que_flush=1.
- inflight=3, redirect granted with if_resp_valid=1 -> resp_drop=1; squash=2; next two responses dropped; third response passes; squash_busy falls after the second drop.
- Second redirect while squash=2, inflight=2, no response -> squash reloads to 2, not 4.
- if_resp_valid at inflight=0 -> counter stays 0, cnt_err=1 until resetn low. Assert resetn mid-squash -> all counters 0 immediately, flush=0xFF.
